// File: rtl/open_list_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : open_list_cmd_issuer
//  Description : Command front-end for a min-priority open list. It accepts
//                enqueue / dequeue / replace commands, checks them against
//                the queue full/empty flags and drops illegal ones with a
//                one-cycle o_err pulse. A legal command produces a one-cycle
//                write/read strobe (ISSUE), then SETTLE_CYCLES idle cycles
//                (SETTLE). Dequeue and replace then present the popped head
//                value (RESP) until the consumer takes it.
//  Ports       : CLK, RSTn (async, active-low)
//                i_cmd_valid/i_cmd_op/i_cmd_data, o_cmd_ready : command in
//                o_wrt/o_read/o_node_f, i_full/i_empty/i_node_f : queue side
//                o_rsp_valid/o_rsp_data, i_rsp_ready             : response
//                o_err                                           : drop pulse
//                o_op_cnt/o_err_cnt (only with OPEN_LIST_STATS_EN) : statistics
//  Options     : `define OPEN_LIST_STATS_EN adds the saturating counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module open_list_cmd_issuer #(
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  i_cmd_valid,
    input  logic [1:0]            i_cmd_op,
    input  logic [DATA_WIDTH-1:0] i_cmd_data,
    output logic                  o_cmd_ready,
    output logic                  o_wrt,
    output logic                  o_read,
    output logic [DATA_WIDTH-1:0] o_node_f,
    input  logic                  i_full,
    input  logic                  i_empty,
    input  logic [DATA_WIDTH-1:0] i_node_f,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    input  logic                  i_rsp_ready,
    output logic                  o_err
`ifdef OPEN_LIST_STATS_EN
    ,
    output logic [15:0]           o_op_cnt,
    output logic [15:0]           o_err_cnt
`endif
);

    localparam logic [1:0] OP_ENQ = 2'b00;
    localparam logic [1:0] OP_DEQ = 2'b01;
    localparam logic [1:0] OP_REP = 2'b10;
    // Counter is loaded with N-1 and SETTLE ends on zero, giving N cycles.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [1:0]              op_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic [3:0]              settle_cnt;
    logic                    err_q;
    logic                    cmd_ready;
    logic                    accept;
    logic                    cmd_legal;

    // Ready is qualified with RSTn so it drops the instant reset asserts and
    // comes up in the very first cycle after release.
    assign cmd_ready = (state == IDLE) && RSTn;
    assign accept    = i_cmd_valid && cmd_ready;

    // Legality is judged on the flags seen in the accept cycle. Replace only
    // needs a non-empty queue: the pop frees the slot the push consumes.
    always_comb begin
        cmd_legal = 1'b0;
        case (i_cmd_op)
            OP_ENQ:  cmd_legal = !i_full;
            OP_DEQ:  cmd_legal = !i_empty;
            OP_REP:  cmd_legal = !i_empty;
            default: cmd_legal = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        o_wrt       = 1'b0;
        o_read      = 1'b0;
        o_node_f    = '0;
        o_rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (accept && cmd_legal) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                o_wrt     = (op_q != OP_DEQ);
                o_read    = (op_q != OP_ENQ);
                o_node_f  = data_q;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_nxt = (op_q == OP_ENQ) ? IDLE : RESP;
                end
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            op_q       <= OP_ENQ;
            data_q     <= '0;
            rsp_data_q <= '0;
            settle_cnt <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            err_q <= accept && !cmd_legal;
            if (accept && cmd_legal) begin
                op_q   <= i_cmd_op;
                data_q <= i_cmd_data;
            end
            if (state == ISSUE) begin
                settle_cnt <= SETTLE_LOAD;
                // Head is sampled while the strobe is up, i.e. before the op.
                if (op_q != OP_ENQ) begin
                    rsp_data_q <= i_node_f;
                end
            end else if ((state == SETTLE) && (settle_cnt != 4'd0)) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
        end
    end

    assign o_cmd_ready = cmd_ready;
    assign o_rsp_data  = rsp_data_q;
    assign o_err       = err_q;

`ifdef OPEN_LIST_STATS_EN
    logic [15:0] op_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            op_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            if (accept && cmd_legal && (op_cnt_q != 16'hFFFF)) begin
                op_cnt_q <= op_cnt_q + 16'd1;
            end
            if (accept && !cmd_legal && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign o_op_cnt  = op_cnt_q;
    assign o_err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire
